pulse_filter_top: RTL and testbench

PULSE_FILTER_TOP -- requirements
Module: pulse_filter_top

---
 rtl/pulse_filter_top.sv | 56 +++++
 tb/tb_pulse_filter_top.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pulse_filter_top.sv
// 32-channel pulse deglitcher: each input is synchronized, then a level change
// reaches pulse_out only after it has held for the shared filter time in clk cycles.
module pulse_filter_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pulse_in,
  input  logic [21:0] filter_coeff,
  output logic [31:0] pulse_out
);

  logic [31:0] sync1_q, sync1_d;
  logic [31:0] sync2_q, sync2_d;
  logic [31:0] out_q, out_d;
  logic [21:0] cnt_q [32];
  logic [21:0] cnt_d [32];
  logic [22:0] eff;

  always_comb begin
    eff = (filter_coeff == '0) ? 23'd1 : {1'b0, filter_coeff};
  end

  // Compare at 23 bits so the maximum coefficient cannot wrap cnt+1.
  always_comb begin
    sync1_d = pulse_in;
    sync2_d = sync1_q;
    out_d   = out_q;
    for (int unsigned i = 0; i < 32; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != out_q[i]) begin
        if (({1'b0, cnt_q[i]} + 23'd1) >= eff) begin
          out_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 22'd1;
        end
      end
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      out_q   <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse_out = out_q;

endmodule

// File: tb/tb_pulse_filter_top.sv
// Bench for pulse_filter_top: directed filter cases plus randomized traffic
// checked each cycle against a history-window reference model.
module tb_pulse_filter_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pulse_in = '0;
  logic [21:0] filter_coeff = 22'd4;
  logic [31:0] pulse_out;

  pulse_filter_top dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse_in     (pulse_in),
    .filter_coeff (filter_coeff),
    .pulse_out    (pulse_out)
  );

  always #25 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: input sampled at every edge, edge index, and per-channel
  // index of the edge at which its output last changed.
  localparam int MAXE = 8000;
  logic [31:0] pin_hist [MAXE];
  int          k = 0;
  int          e_start = 0;
  int          last_chg [32];
  logic [31:0] m_out = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Level the filter sees at edge j: the input sampled two edges earlier.
  function automatic logic seen(input int j, input int ch);
    if (j - 2 < e_start) return 1'b0;
    return pin_hist[j - 2][ch];
  endfunction

  // Output flips at edge k when the seen level has differed from the output
  // on each of the last eff edges since the previous change.
  task automatic model_edge();
    int eff;
    int run;
    eff = (filter_coeff == 0) ? 1 : int'(filter_coeff);
    if (rst_n) begin
      e_start = k + 1;
      m_out   = '0;
      for (int ch = 0; ch < 32; ch++) last_chg[ch] = k;
    end else begin
      if (k < MAXE) pin_hist[k] = pulse_in;
      for (int ch = 0; ch < 32; ch++) begin
        run = 0;
        for (int j = k; j > last_chg[ch] && run < eff; j--) begin
          if (seen(j, ch) != m_out[ch]) run++;
          else break;
        end
        if (run >= eff) begin
          m_out[ch]    = ~m_out[ch];
          last_chg[ch] = k;
        end
      end
    end
    k++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("pulse_out", pulse_out, m_out);
    @(negedge clk);
  endtask

  task automatic pulse_test(input string tag, input int ch, input int width,
                            input int glitch_at, input int exp_rise, input int exp_fall);
    int rise = 0;
    int fall = 0;
    pulse_in     = '0;
    pulse_in[ch] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (c == glitch_at) pulse_in[ch] = 1'b0;
      else if (glitch_at != 0 && c == glitch_at + 1) pulse_in[ch] = 1'b1;
      if (c == width + 1) pulse_in[ch] = 1'b0;
      tick();
      if (rise == 0 && pulse_out[ch]) rise = c;
      else if (rise != 0 && fall == 0 && !pulse_out[ch]) fall = c;
    end
    chk({tag, "_rise"}, rise, exp_rise);
    chk({tag, "_fall"}, fall, exp_fall);
  endtask

  initial begin
    logic [21:0] cnt_or;
    int rise;
    for (int ch = 0; ch < 32; ch++) last_chg[ch] = -1;

    pulse_in = $urandom;
    #10;
    chk("rst_out", pulse_out, 32'h0);
    tick();
    pulse_in = $urandom;
    tick();
    chk("rst_out_held", pulse_out, 32'h0);
    cnt_or = '0;
    for (int i = 0; i < 32; i++) cnt_or |= dut.cnt_q[i];
    chk("rst_cnt", {10'd0, cnt_or}, 32'h0);
    pulse_in = '0;
    rst_n    = 1'b0;

    filter_coeff = 22'd4;
    pulse_test("short2", 0, 2, 0, 0, 0);
    pulse_test("w4", 0, 4, 0, 6, 10);
    pulse_test("w6", 1, 6, 0, 6, 12);
    pulse_test("glitch", 2, 17, 9, 6, 23);
    filter_coeff = 22'd0;
    pulse_test("coef0", 4, 1, 0, 3, 4);
    filter_coeff = 22'd1;
    pulse_test("coef1", 5, 1, 0, 3, 4);
    filter_coeff = 22'd4;

    // Reset mid-count, input held through reset.
    pulse_in    = '0;
    pulse_in[3] = 1'b1;
    repeat (4) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_async", pulse_out, 32'h0);
    tick();
    tick();
    rst_n = 1'b0;
    rise  = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (rise == 0 && pulse_out[3]) rise = c;
    end
    chk("rst_release_rise", rise, 6);
    pulse_in = '0;
    repeat (10) tick();

    // Maximum coefficient holds everything, then lowering it releases at once.
    filter_coeff = '1;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) pulse_in = 32'hA5A5_5A5A;
      tick();
    end
    chk("maxcoef_hold", pulse_out, 32'h0);
    filter_coeff = 22'd2;
    tick();
    chk("lower_coef", pulse_out, 32'hA5A5_5A5A);
    pulse_in     = '0;
    filter_coeff = 22'd4;
    repeat (10) tick();

    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) filter_coeff = 22'($urandom_range(0, 6));
      pulse_in = pulse_in ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b1;
        #1;
        chk("rnd_rst_async", pulse_out, 32'h0);
        tick();
        rst_n = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
